// File: rtl/flag_pkg.sv
// Shared definitions for the status-flag unit: flag bit positions, the packed
// flag vector, condition-code encodings and the condition evaluator.
package flag_pkg;

    localparam int FLG_Z  = 0;
    localparam int FLG_O  = 1;
    localparam int FLG_C  = 2;
    localparam int FLG_S  = 3;
    localparam int NFLAGS = 4;

    // Bit order {S,C,O,Z}, matching the update mask.
    typedef logic [NFLAGS-1:0] flags_t;

    typedef enum logic [3:0] {
        COND_AL = 4'd0,   // always
        COND_EQ = 4'd1,   // Z
        COND_NE = 4'd2,   // !Z
        COND_CS = 4'd3,   // C
        COND_CC = 4'd4,   // !C
        COND_MI = 4'd5,   // S
        COND_PL = 4'd6,   // !S
        COND_VS = 4'd7,   // O
        COND_VC = 4'd8,   // !O
        COND_LT = 4'd9,   // signed less-than
        COND_GE = 4'd10,  // signed greater-or-equal
        COND_LS = 4'd11,  // unsigned lower-or-same
        COND_HI = 4'd12,  // unsigned higher
        COND_LE = 4'd13,  // signed less-or-equal
        COND_GT = 4'd14,  // signed greater-than
        COND_NV = 4'd15   // never
    } cond_t;

    // Evaluate one condition code against a flag vector.
    function automatic logic eval_cond(input flags_t f, input cond_t c);
        logic z;
        logic o;
        logic cy;
        logic s;
        logic res;
        z   = f[FLG_Z];
        o   = f[FLG_O];
        cy  = f[FLG_C];
        s   = f[FLG_S];
        res = 1'b0;
        case (c)
            COND_AL: res = 1'b1;
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = cy;
            COND_CC: res = ~cy;
            COND_MI: res = s;
            COND_PL: res = ~s;
            COND_VS: res = o;
            COND_VC: res = ~o;
            COND_LT: res = s ^ o;
            COND_GE: res = ~(s ^ o);
            COND_LS: res = cy | z;
            COND_HI: res = ~(cy | z);
            COND_LE: res = z | (s ^ o);
            COND_GT: res = ~(z | (s ^ o));
            COND_NV: res = 1'b0;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved flag vectors with depth tracking and a sticky error bit that
// records push-on-full and pop-on-empty attempts.
module flag_stack
    import flag_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_err_i,
    input  flags_t        wr_flags_i,
    output flags_t        top_flags_o,
    output logic          pop_ok_o,
    output logic [DW-1:0] depth_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          err_o
);

    flags_t        stack_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic          err_q;
    logic          err_d;
    logic          push_only;
    logic          pop_only;
    logic          push_ok;
    logic          pop_ok;
    logic          full;
    logic          empty;

    // Simultaneous push and pop cancel: nothing moves and no error is raised.
    assign push_only = push_i & ~pop_i;
    assign pop_only  = pop_i & ~push_i;
    assign full      = (depth_q == DW'(DEPTH));
    assign empty     = (depth_q == '0);
    assign push_ok   = push_only & ~full;
    assign pop_ok    = pop_only & ~empty;

    // Next depth and sticky error; a fresh error outranks clear_err.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        depth_d = depth_q;
        if (push_ok) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_ok) begin
            depth_d = depth_q - DW'(1);
        end
        err_d = (push_only & full) | (pop_only & empty) | (err_q & ~clear_err_i);
    end

    // Control state: depth counter and error flag, asynchronously reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    // Stack storage: write the saved flags into the slot at the current depth.
    // NOTE: storage has no reset; depth alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_ok && depth_q == DW'(i)) begin
                stack_q[i] <= wr_flags_i;
            end
        end
    end

    // Read the top-of-stack entry (slot depth-1); zero when empty.
    always_comb begin
        top_flags_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_flags_o = stack_q[i];
            end
        end
    end

    assign pop_ok_o = pop_ok;
    assign depth_o  = depth_q;
    assign full_o   = full;
    assign empty_o  = empty;
    assign err_o    = err_q;

endmodule

// File: rtl/flag_unit.sv
// Status-flag unit: captures Z/O/C/S from the ALU result with per-flag masking,
// saves/restores them through a hardware stack and evaluates branch conditions.
module flag_unit
    import flag_pkg::*;
#(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    localparam int DW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             overflow,
    input  logic             carry,
    input  logic             we,
    input  logic [3:0]       upd_mask,
    input  logic             push,
    input  logic             pop,
    input  logic             clear_err,
    input  logic [3:0]       cond,
    output logic             zflag,
    output logic             oflag,
    output logic             cflag,
    output logic             sflag,
    output logic             cond_true,
    output logic [DW-1:0]    depth,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    flags_t flags_q;
    flags_t flags_d;
    flags_t alu_flags;
    flags_t top_flags;
    logic   pop_ok;
    logic   we_blocked;

    // Any pop request without a push suppresses the update, even when the
    // stack is empty and nothing is actually restored.
    assign we_blocked = pop & ~push;

    // Flags derived from the current ALU result.
    always_comb begin
        alu_flags        = '0;
        alu_flags[FLG_Z] = (data_in == '0);
        alu_flags[FLG_O] = overflow;
        alu_flags[FLG_C] = carry;
        alu_flags[FLG_S] = data_in[WIDTH-1];
    end

    // Next live flags: a restore wins, otherwise a masked update.
    always_comb begin
        flags_d = flags_q;
        if (pop_ok) begin
            flags_d = top_flags;
        end else if (we && !we_blocked) begin
            flags_d = (flags_q & ~upd_mask) | (alu_flags & upd_mask);
        end
    end

    // Live flag register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else begin
            flags_q <= flags_d;
        end
    end

    // The stack always saves the pre-update live flags.
    flag_stack #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_stack (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .pop_i       (pop),
        .clear_err_i (clear_err),
        .wr_flags_i  (flags_q),
        .top_flags_o (top_flags),
        .pop_ok_o    (pop_ok),
        .depth_o     (depth),
        .full_o      (stack_full),
        .empty_o     (stack_empty),
        .err_o       (stack_err)
    );

    assign zflag     = flags_q[FLG_Z];
    assign oflag     = flags_q[FLG_O];
    assign cflag     = flags_q[FLG_C];
    assign sflag     = flags_q[FLG_S];
    assign cond_true = eval_cond(flags_q, cond_t'(cond));

endmodule

// File: tb/tb_flag_unit.sv
// Scoreboard bench for flag_unit: the stimulus side updates a queue-based
// reference model and queues the expected outputs; a negedge monitor pops
// and compares them against the DUT.
module tb_flag_unit;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] data_in;
    logic             overflow;
    logic             carry;
    logic             we;
    logic [3:0]       upd_mask;
    logic             push;
    logic             pop;
    logic             clear_err;
    logic [3:0]       cond;
    logic             zflag;
    logic             oflag;
    logic             cflag;
    logic             sflag;
    logic             cond_true;
    logic [DW-1:0]    depth;
    logic             stack_full;
    logic             stack_empty;
    logic             stack_err;

    flag_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .overflow    (overflow),
        .carry       (carry),
        .we          (we),
        .upd_mask    (upd_mask),
        .push        (push),
        .pop         (pop),
        .clear_err   (clear_err),
        .cond        (cond),
        .zflag       (zflag),
        .oflag       (oflag),
        .cflag       (cflag),
        .sflag       (sflag),
        .cond_true   (cond_true),
        .depth       (depth),
        .stack_full  (stack_full),
        .stack_empty (stack_empty),
        .stack_err   (stack_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] flags;   // {S,C,O,Z}
        int         dep;
        logic       err;
        logic       ct;
    } exp_t;

    exp_t       exp_q[$];
    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    logic       m_err;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Condition truth table from the branch mnemonics.
    function automatic logic ref_cond(input logic [3:0] f, input int c);
        bit z  = f[0];
        bit o  = f[1];
        bit cy = f[2];
        bit s  = f[3];
        bit signed_lt = (s != o);
        case (c)
            0:  return 1'b1;
            1:  return z;
            2:  return !z;
            3:  return cy;
            4:  return !cy;
            5:  return s;
            6:  return !s;
            7:  return o;
            8:  return !o;
            9:  return signed_lt;
            10: return !signed_lt;
            11: return cy || z;
            12: return !(cy || z);
            13: return z || signed_lt;
            14: return !(z || signed_lt);
            default: return 1'b0;
        endcase
    endfunction

    // Drive one cycle, advance the model at the edge, queue the expectation.
    task automatic step(input logic w, input logic [3:0] m, input logic [7:0] d,
                        input logic ov, input logic cy, input logic pu,
                        input logic po, input logic clr, input logic [3:0] c);
        logic [3:0] fresh;
        logic       new_err;
        bit         skip_we;
        exp_t       e;
        we = w; upd_mask = m; data_in = d; overflow = ov; carry = cy;
        push = pu; pop = po; clear_err = clr; cond = c;
        @(posedge clk);
        fresh   = {d[7], cy, ov, (d == 8'h00)};
        new_err = 1'b0;
        skip_we = 0;
        if (pu && !po) begin
            if (m_stack.size() == DEPTH) new_err = 1'b1;
            else m_stack.push_back(m_flags);
        end
        if (po && !pu) begin
            skip_we = 1;
            if (m_stack.size() == 0) new_err = 1'b1;
            else m_flags = m_stack.pop_back();
        end
        if (w && !skip_we) begin
            for (int i = 0; i < 4; i++) if (m[i]) m_flags[i] = fresh[i];
        end
        m_err   = new_err || (m_err && !clr);
        e.flags = m_flags;
        e.dep   = m_stack.size();
        e.err   = m_err;
        e.ct    = ref_cond(m_flags, int'(c));
        exp_q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input logic [3:0] c);
        step(1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, c);
    endtask

    // Monitor: every negedge with a pending expectation, compare all outputs.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("flags", int'({sflag, cflag, oflag, zflag}), int'(e.flags));
            check("depth", int'(depth), e.dep);
            check("stack_full", int'(stack_full), int'(e.dep == DEPTH));
            check("stack_empty", int'(stack_empty), int'(e.dep == 0));
            check("stack_err", int'(stack_err), int'(e.err));
            check("cond_true", int'(cond_true), int'(e.ct));
        end
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_flags"}, int'({sflag, cflag, oflag, zflag}), 0);
        check({tag, "_depth"}, int'(depth), 0);
        check({tag, "_empty"}, int'(stack_empty), 1);
        check({tag, "_full"}, int'(stack_full), 0);
        check({tag, "_err"}, int'(stack_err), 0);
    endtask

    initial begin
        reset = 1'b1;
        we = 0; upd_mask = 0; data_in = 0; overflow = 0; carry = 0;
        push = 0; pop = 0; clear_err = 0; cond = 0;
        m_flags = 4'h0; m_err = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_state("reset");
        #1 reset = 1'b0;

        // 1: Z and C set by a zero result with carry; unsigned-le true.
        step(1, 4'hF, 8'h00, 0, 1, 0, 0, 0, 4'd11);
        // 2: sign from the MSB, then a Z-only masked update.
        step(1, 4'hF, 8'h80, 0, 0, 0, 0, 0, 4'd5);
        step(1, 4'h1, 8'h00, 1, 1, 0, 0, 0, 4'd1);
        // 3: flags 1010, push with update, then pop restores.
        step(1, 4'hF, 8'h80, 1, 0, 0, 0, 0, 4'd9);
        step(1, 4'hF, 8'h00, 0, 0, 1, 0, 0, 4'd1);
        step(0, 4'h0, 8'h00, 0, 0, 0, 1, 0, 4'd7);
        // 4: fill with distinct entries, overflow, clear, drain LIFO, underflow.
        for (int i = 0; i < 5; i++) begin
            step(1, 4'hF, 8'(i * 8'h41), i[0], i[1], 1, 0, 0, 4'(i));
        end
        step(0, 4'h0, 8'h00, 0, 0, 0, 0, 1, 4'd0);
        for (int i = 0; i < 5; i++) step(1, 4'hF, 8'h00, 1, 1, 0, 1, 0, 4'(i + 3));
        step(0, 4'h0, 8'h00, 0, 0, 0, 0, 1, 4'd0);
        // 5: pop beats we; push+pop at depth 2 is a no-op.
        step(1, 4'hF, 8'hFF, 0, 1, 1, 0, 0, 4'd3);
        step(1, 4'hF, 8'h00, 1, 0, 0, 1, 0, 4'd1);
        step(1, 4'hF, 8'h01, 1, 1, 1, 0, 0, 4'd12);
        step(1, 4'hF, 8'h80, 0, 0, 1, 0, 0, 4'd13);
        step(1, 4'hF, 8'h00, 0, 0, 1, 1, 0, 4'd14);
        // 6: reset asynchronously at depth 3.
        step(0, 4'h0, 8'h00, 0, 0, 1, 0, 0, 4'd0);
        check("pre_reset_depth", int'(depth), 3);
        #2 reset = 1'b1;
        #1 check_reset_state("async_reset");
        m_flags = 4'h0; m_err = 1'b0; m_stack.delete();
        @(negedge clk);
        #1 reset = 1'b0;

        // Condition sweep over every flag combination.
        for (int f = 0; f < 16; f++) begin
            step(1, 4'h1, (f[0] ? 8'h00 : 8'h01), 0, 0, 0, 0, 0, 4'd0);
            step(1, 4'hE, (f[3] ? 8'h80 : 8'h01), f[1], f[2], 0, 0, 0, 4'd0);
            for (int c = 0; c < 16; c++) idle(4'(c));
        end

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
                 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 7) == 0), 4'($urandom));
        end

        // Bounded drain of the scoreboard.
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(negedge clk);
        #1 check("scoreboard_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
Name: flag_unit

Overview:
- Parametrised status-flag unit; successor to the 8-bit four-flag compare register.
- Captures zero/overflow/carry/sign from the ALU result bus with per-flag update masking.
- Provides a hardware flag stack (push on call/interrupt, pop on return) and a registered-flag condition-code evaluator feeding the branch unit.
- Sits between the ALU output and the control/sequencer logic.

Parameters:
- WIDTH, 8, ALU result width; Z and S are computed over all WIDTH bits.
- DEPTH, 4, flag stack entries; legal range 1..16.
- DW, $clog2(DEPTH+1), derived localparam; width of the depth counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  WIDTH  ALU result.
- overflow  in  1  ALU signed-overflow.
- carry  in  1  ALU carry/borrow.
- we  in  1  flag update strobe.
- upd_mask  in  4  per-flag write enable, bit order {S,C,O,Z}.
- push  in  1  save live flags to the stack.
- pop  in  1  restore live flags from the stack top.
- clear_err  in  1  clears stack_err.
- cond  in  4  condition-code select.
- zflag, oflag, cflag, sflag  out  1 each  live flags (registered).
- cond_true  out  1  selected condition evaluated on the live flags (combinational).
- depth  out  DW  number of occupied stack entries.
- stack_full  out  1  depth == DEPTH.
- stack_empty  out  1  depth == 0.
- stack_err  out  1  sticky push-overflow/pop-underflow indicator.

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - all flags 0, depth 0, stack_err 0.
  - stack contents are don't-care and are not reset.
  - reset mid-operation discards any in-flight push/pop.
- Flag update (we=1, no effective pop):
  - next cycle, Z = (data_in == 0) over all WIDTH bits.
  - S = data_in[WIDTH-1], O = overflow, C = carry.
  - each flag updates only if its upd_mask bit is 1; otherwise it holds.
- Latency: flags are visible 1 cycle after the we edge.
- cond_true is purely combinational from the registered flags, with no extra latency.
- Push (push=1, pop=0, not full):
  - stack[depth] <= pre-update live flags; depth+1.
  - if we is also high, the live flags take the new values, so the saved copy is the old state.
- Pop (pop=1, push=0, not empty):
  - live flags <= stack[depth-1]; depth-1.
  - pop has priority over we: a we in the same cycle is ignored entirely.
- push=1 and pop=1 together: stack and depth unchanged, we processed normally, no error.
- Push when full: stack and depth unchanged, stack_err <= 1, we still processed.
- Pop when empty: flags unchanged, stack_err <= 1, we ignored.
- stack_err:
  - sticky until clear_err=1.
  - if a new error and clear_err occur in the same cycle, the error wins and stack_err stays 1.
- Condition codes (cond value -> cond_true):
  - 0: 1 (always).
  - 1: Z.  2: !Z.
  - 3: C.  4: !C.
  - 5: S.  6: !S.
  - 7: O.  8: !O.
  - 9: S^O (signed lt).  10: !(S^O) (signed ge).
  - 11: C|Z (unsigned le).  12: !(C|Z) (unsigned gt).
  - 13: Z|(S^O) (signed le).  14: !(Z|(S^O)) (signed gt).
  - 15: 0 (never).

Decomposition:
- Shared package flag_pkg:
  - flag bit index constants FLG_Z=0, FLG_O=1, FLG_C=2, FLG_S=3.
  - packed flags_t typedef (4 bits).
  - cond_t enum with the 16 codes above, used by the decoder and control unit.
- One natural sub-module: flag_stack.
  - DEPTH x flags_t register array, depth counter, full/empty, push/pop arbitration and error detection.
  - flag_unit instantiates it and holds the live-flag register and the condition evaluator.

Test Plan:
1. Reset then we=1, mask=4'hF, data_in=8'h00, ov=0, cy=1 -> Z=1, C=1, S=0, O=0; cond=11 -> cond_true=1.
2. WIDTH=8, data_in=8'h80, mask=4'hF -> Z=0, S=1 (confirms Z over all bits); mask=4'b0001 with data_in=8'h00 -> only Z=1, S stays 1.
3. Set flags 4'b1010, push with simultaneous we (data_in=0, mask=F) -> live Z=1, depth=1; pop -> live flags=4'b1010, depth=0.
4. DEPTH=4: five pushes -> depth=4, stack_full=1, stack_err=1 on the 5th; clear_err -> 0; four pops return entries in LIFO order; 5th pop -> stack_err=1, flags unchanged.
5. Pop and we in the same cycle -> restored flags win; push+pop same cycle with depth=2 -> depth stays 2, no error.
6. Assert reset mid-sequence at depth=3 -> all flags 0, depth=0, stack_empty=1 immediately; sweep cond 0..15 over all 16 flag combinations against a reference model.
